mips_multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback. Drives every datapath mux select and enable, plus the 2-bit ALUOp consumed by alu_control.
- Adds a memory request/ready handshake so that instruction and data accesses may stall for any number of cycles.

---
 rtl/mips_multicycle_control_pkg.sv | 45 ++++
 rtl/mips_multicycle_control_if.sv | 41 ++++
 rtl/mips_multicycle_control.sv | 136 +++++++++++++
 tb/tb_mips_multicycle_control.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM:
// opcode/funct values, ALUOp codes and the exported state encoding.
package mips_multicycle_control_pkg;

   // Opcodes (instruction[31:26]) recognised by the controller
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   // funct field value that turns an R-type into a register jump
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   // ALUOp codes consumed by alu_control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Exported state encoding; values 14 and 15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECUTE  = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_ADDIEX   = 4'd10,
      S_ADDIWB   = 4'd11,
      S_JUMP     = 4'd12,
      S_JR       = 4'd13
   } state_t;

   // True for every opcode the controller knows how to sequence
   function automatic logic is_supported(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the main control FSM and the multicycle datapath/memory.
//
// Memory handshake: the controller holds mem_req (and IorD/MemWrite) steady
// while it wants an access; the access completes in the cycle where both
// mem_req and mem_ready are 1. mem_ready is ignored whenever mem_req is 0.
interface mips_multicycle_control_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               zero;
   logic               mem_ready;
   logic               mem_req;
   logic               IorD;
   logic               MemWrite;
   logic               IRWrite;
   logic               RegDst;
   logic               MemtoReg;
   logic               RegWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ALUOp;
   logic [1:0]         PCSrc;
   logic               PCEn;
   logic               illegal_op;
   logic [STATE_W-1:0] state;

   // Controller side
   modport master (
      input  opcode, funct, zero, mem_ready,
      output mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state
   );

   // Datapath / memory side
   modport slave (
      output opcode, funct, zero, mem_ready,
      input  mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS: fetch, decode, execute, memory,
// writeback, with memory stalls on a req/ready handshake. Outputs decode
// from the state register; FETCH loads IR/PC only on the completing cycle,
// DECODE flags unsupported opcodes, and PCEn folds in the branch zero flag.
module mips_multicycle_control
   import mips_multicycle_control_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   mips_multicycle_control_if.master bus
);

   state_t state_q;
   state_t next_state;
   logic   pc_write;
   logic   branch;

   // State register; reset drops straight to RESET so no write strobe survives
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_RESET;
      else      state_q <= next_state;
   end

   // Next-state decode; unused encodings fall back to FETCH
   always_comb begin
      next_state = state_q;
      case (state_q)
         S_RESET:    next_state = S_FETCH;
         S_FETCH:    if (bus.mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = (bus.funct == FUNCT_JR) ? S_JR : S_EXECUTE;
               OP_BEQ:       next_state = S_BRANCH;
               OP_ADDI:      next_state = S_ADDIEX;
               OP_J:         next_state = S_JUMP;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEMADR:   next_state = (bus.opcode == OP_LW) ? S_MEMREAD :
                                  (bus.opcode == OP_SW) ? S_MEMWRITE : S_FETCH;
         S_MEMREAD:  if (bus.mem_ready) next_state = S_MEMWB;
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: if (bus.mem_ready) next_state = S_FETCH;
         S_EXECUTE:  next_state = S_ALUWB;
         S_ALUWB:    next_state = S_FETCH;
         S_BRANCH:   next_state = S_FETCH;
         S_ADDIEX:   next_state = S_ADDIWB;
         S_ADDIWB:   next_state = S_FETCH;
         S_JUMP:     next_state = S_FETCH;
         S_JR:       next_state = S_FETCH;
         default:    next_state = S_FETCH;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      bus.mem_req    = 1'b0;
      bus.IorD       = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegDst     = 1'b0;
      bus.MemtoReg   = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'b00;
      bus.ALUOp      = ALUOP_ADD;
      bus.PCSrc      = 2'b00;
      bus.illegal_op = 1'b0;
      pc_write       = 1'b0;
      branch         = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC+4 computed every cycle, committed only when the fetch completes
            bus.mem_req = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = bus.mem_ready;
            pc_write    = bus.mem_ready;
         end
         S_DECODE: begin
            bus.ALUSrcB    = 2'b11;
            bus.illegal_op = !is_supported(bus.opcode);
         end
         S_MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         S_MEMREAD: begin
            bus.mem_req = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEMWB: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_MEMWRITE: begin
            bus.mem_req  = 1'b1;
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
         end
         S_EXECUTE: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = ALUOP_SUB;
            bus.PCSrc   = 2'b01;
            branch      = 1'b1;
         end
         S_ADDIEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
         end
         S_ADDIWB: bus.RegWrite = 1'b1;
         S_JUMP: begin
            bus.PCSrc = 2'b10;
            pc_write  = 1'b1;
         end
         S_JR: begin
            bus.PCSrc = 2'b11;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
      bus.PCEn  = pc_write | (branch & bus.zero);
      bus.state = STATE_W'(state_q);
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed instructions from the test
// plan followed by random instructions with random stall lengths.
module tb_mips_multicycle_control;
   import mips_multicycle_control_pkg::*;

   localparam int STATE_W = 4;

   typedef struct packed {
      logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
      logic [1:0] src_b, alu_op, pc_src;
      logic       pc_en, illegal;
   } ctrl_s;

   logic   clk = 1'b0;
   logic   rst;
   int     total_cnt = 0;
   int     bad_cnt = 0;
   state_t plan_q[$];

   mips_multicycle_control_if #(.STATE_W(STATE_W)) bus ();

   mips_multicycle_control #(.STATE_W(STATE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic ctrl_s observed();
      ctrl_s c;
      c = {bus.mem_req, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
           bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.PCEn,
           bus.illegal_op};
      return c;
   endfunction

   function automatic logic known_op(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   // ---------------- reference model ----------------
   // Phase list an instruction walks through, straight from the instruction class.
   function automatic void build_plan(input logic [5:0] op, input logic [5:0] fn);
      plan_q.delete();
      plan_q.push_back(S_FETCH);
      plan_q.push_back(S_DECODE);
      if (op == 6'b100011) begin
         plan_q.push_back(S_MEMADR); plan_q.push_back(S_MEMREAD); plan_q.push_back(S_MEMWB);
      end else if (op == 6'b101011) begin
         plan_q.push_back(S_MEMADR); plan_q.push_back(S_MEMWRITE);
      end else if (op == 6'b000000) begin
         if (fn == 6'b001000) plan_q.push_back(S_JR);
         else begin plan_q.push_back(S_EXECUTE); plan_q.push_back(S_ALUWB); end
      end else if (op == 6'b000100) plan_q.push_back(S_BRANCH);
      else if (op == 6'b001000) begin
         plan_q.push_back(S_ADDIEX); plan_q.push_back(S_ADDIWB);
      end else if (op == 6'b000010) plan_q.push_back(S_JUMP);
   endfunction

   // Control word each phase must show (unlisted fields are 0).
   function automatic ctrl_s exp_ctrl(input state_t p, input logic rdy, input logic z,
                                      input logic [5:0] op);
      ctrl_s c;
      c = '0;
      case (p)
         S_FETCH:    begin c.mem_req = 1; c.src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy; end
         S_DECODE:   begin c.src_b = 2'b11; c.illegal = !known_op(op); end
         S_MEMADR:   begin c.src_a = 1; c.src_b = 2'b10; end
         S_MEMREAD:  begin c.mem_req = 1; c.iord = 1; end
         S_MEMWB:    begin c.mem_to_reg = 1; c.reg_write = 1; end
         S_MEMWRITE: begin c.mem_req = 1; c.iord = 1; c.mem_write = 1; end
         S_EXECUTE:  begin c.src_a = 1; c.alu_op = 2'b10; end
         S_ALUWB:    begin c.reg_dst = 1; c.reg_write = 1; end
         S_BRANCH:   begin c.src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
         S_ADDIEX:   begin c.src_a = 1; c.src_b = 2'b10; end
         S_ADDIWB:   c.reg_write = 1;
         S_JUMP:     begin c.pc_src = 2'b10; c.pc_en = 1; end
         S_JR:       begin c.pc_src = 2'b11; c.pc_en = 1; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   // ---------------- drivers ----------------
   // Entered just after a clock edge with the DUT in FETCH; leaves the same way.
   // zmode: 0/1 forces zero, anything else randomises it each cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fetch_waits, input int mem_waits, input int zmode);
      int    n_ir = 0, n_rw = 0, n_mw = 0, n_pc = 0, n_ill = 0;
      int    exp_rw, exp_mw, exp_pc, exp_ill;
      int    waits;
      logic  is_mem, rdy, z, branch_z;
      ctrl_s got;
      branch_z = 1'b0;
      build_plan(op, fn);
      bus.opcode = op;
      bus.funct  = fn;
      foreach (plan_q[i]) begin
         is_mem = plan_q[i] inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
         waits  = (plan_q[i] == S_FETCH) ? fetch_waits : (is_mem ? mem_waits : 0);
         for (int w = 0; w <= waits; w++) begin
            rdy = is_mem ? (w == waits) : 1'($urandom_range(0, 1));
            z   = (zmode == 0 || zmode == 1) ? 1'(zmode) : 1'($urandom_range(0, 1));
            if (plan_q[i] == S_BRANCH) branch_z = z;
            bus.mem_ready = rdy;
            bus.zero      = z;
            @(negedge clk);
            got = observed();
            check($sformatf("state_%s", plan_q[i].name()), 32'(bus.state), 32'(plan_q[i]));
            check($sformatf("ctrl_%s", plan_q[i].name()), 32'(got),
                  32'(exp_ctrl(plan_q[i], rdy, z, op)));
            n_ir  += int'(got.ir_write);
            n_rw  += int'(got.reg_write);
            n_mw  += int'(got.mem_write);
            n_pc  += int'(got.pc_en);
            n_ill += int'(got.illegal);
            @(posedge clk);
            #1;
         end
      end
      // Per-instruction event totals from the instruction class alone
      exp_rw  = (op == 6'b100011 || op == 6'b001000 || (op == 6'b000000 && fn != 6'b001000)) ? 1 : 0;
      exp_mw  = (op == 6'b101011) ? mem_waits + 1 : 0;
      exp_pc  = 1 + ((op == 6'b000010 || (op == 6'b000000 && fn == 6'b001000)) ? 1 : 0)
                  + ((op == 6'b000100 && branch_z) ? 1 : 0);
      exp_ill = known_op(op) ? 0 : 1;
      check("irwrite_count", 32'(n_ir), 32'd1);
      check("regwrite_count", 32'(n_rw), 32'(exp_rw));
      check("memwrite_cycles", 32'(n_mw), 32'(exp_mw));
      check("pcen_count", 32'(n_pc), 32'(exp_pc));
      check("illegal_pulses", 32'(n_ill), 32'(exp_ill));
   endtask

   // Reset pulled in the middle of a stalled LW read, then released.
   task automatic reset_mid_memread();
      int guard;
      bus.opcode = 6'b100011; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("pre_reset_state", 32'(bus.state), 32'(S_MEMREAD));
      #1 rst = 1'b0;
      #1;
      check("async_reset_state", 32'(bus.state), 32'(S_RESET));
      check("async_reset_ctrl", 32'(observed()), 32'd0);
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      check("held_reset_ctrl", 32'(observed()), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("release_edge1", 32'(bus.state), 32'(S_FETCH));
      @(posedge clk); #1;
      check("release_edge2", 32'(bus.state), 32'(S_DECODE));
      guard = 0;
      while (bus.state != STATE_W'(S_FETCH) && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain_to_fetch", 32'(bus.state), 32'(S_FETCH));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [5:0] op, fn;
      rst = 1'b0;
      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      #1;
      check("reset_state", 32'(bus.state), 32'(S_RESET));
      check("reset_ctrl", 32'(observed()), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("first_fetch", 32'(bus.state), 32'(S_FETCH));

      // Directed cases
      run_instr(6'b100011, 6'b000000, 2, 3, 2);   // LW with stalls: 10 cycles
      run_instr(6'b000000, 6'b100000, 0, 0, 2);   // R-type add
      run_instr(6'b000000, 6'b001000, 0, 0, 2);   // JR
      run_instr(6'b000100, 6'b000000, 0, 0, 1);   // BEQ taken
      run_instr(6'b000100, 6'b000000, 0, 0, 0);   // BEQ not taken
      run_instr(6'b101011, 6'b000000, 0, 0, 2);   // SW, no stall
      run_instr(6'b000010, 6'b000000, 1, 0, 2);   // J
      run_instr(6'b001000, 6'b000000, 0, 0, 2);   // ADDI
      run_instr(6'b111111, 6'b000000, 0, 0, 2);   // illegal
      reset_mid_memread();

      // Random instructions with random stall lengths
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 7))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            6: op = 6'b000000;
            default: begin
               do op = 6'($urandom_range(0, 63)); while (known_op(op));
            end
         endcase
         fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
         run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
